// File: rtl/abs_diff_err_sweeper_pkg.sv
// Shared types and default widths for the abs-diff error sweeper.
// Derived widths follow from the default DUT input/output widths.
package abs_diff_eval_pkg;

    localparam int I_W_D    = 8;
    localparam int O_W_D    = 5;
    localparam int ET_D     = 16;
    localparam int SETTLE_D = 1;

    localparam int OP_W  = I_W_D / 2;
    localparam int SUM_W = I_W_D + O_W_D;
    localparam int CNT_W = I_W_D + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/abs_diff_err_sweeper_if.sv
// Control, approximate-circuit bus and result signals of the sweeper.
// master = harness/software side, slave = sweeper.
interface abs_diff_err_sweeper_if #(
    parameter int I_W = 8,
    parameter int O_W = 5
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [I_W-1:0]   dut_in;
    logic [O_W-1:0]   dut_out;
    logic [O_W-1:0]   max_err;
    logic [I_W+O_W-1:0] err_sum;
    logic [I_W:0]     viol_cnt;
    logic [I_W-1:0]   first_fail_vec;
    logic             pass;

    modport master (
        output start, abort, dut_out,
        input  busy, done, dut_in, max_err,
        input  err_sum, viol_cnt, first_fail_vec, pass
    );

    modport slave (
        input  start, abort, dut_out,
        output busy, done, dut_in, max_err,
        output err_sum, viol_cnt, first_fail_vec, pass
    );
endinterface

// File: rtl/abs_diff_exact_ref.sv
// Exact |a-b| golden model, purely combinational.
// Result is zero-extended (or truncated) to the output width.
module abs_diff_exact_ref #(
    parameter int OP_W = 4,
    parameter int O_W  = 5
) (
    input  logic [OP_W-1:0] i_a,
    input  logic [OP_W-1:0] i_b,
    output logic [O_W-1:0]  o_abs
);
    logic [OP_W-1:0] w_d;

    assign w_d   = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    assign o_abs = O_W'(w_d);
endmodule

// File: rtl/abs_diff_err_sweeper.sv
// Exhaustive sweeper: drives every input vector to an approximate
// abs-diff circuit and accumulates error statistics against |a-b|.
module abs_diff_err_sweeper
    import abs_diff_eval_pkg::*;
#(
    parameter int I_W    = I_W_D,
    parameter int O_W    = O_W_D,
    parameter int ET     = ET_D,
    parameter int SETTLE = SETTLE_D
) (
    input logic                   clk,
    input logic                   rst_n,
    abs_diff_err_sweeper_if.slave bus
);
    localparam int OPW = I_W / 2;
    localparam int SW  = I_W + O_W;
    localparam int CW  = I_W + 1;
    localparam int STW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LAST = {1'b0, {I_W{1'b1}}};

    state_t           r_state;
    state_t           w_nxt;
    logic [CW-1:0]    r_vec;
    logic [STW-1:0]   r_set;
    logic [I_W-1:0]   r_dut_in;
    logic [O_W-1:0]   r_max;
    logic [SW-1:0]    r_sum;
    logic [CW-1:0]    r_viol;
    logic [I_W-1:0]   r_ffv;
    logic             r_done;
    logic             w_busy;
    logic             w_accept;
    logic             w_abort;
    logic             w_last;
    logic [O_W-1:0]   w_exact;
    logic [O_W-1:0]   w_err;
    logic             w_viol;

    abs_diff_exact_ref #(
        .OP_W (OPW),
        .O_W  (O_W)
    ) u_ref (
        .i_a   (r_dut_in[OPW-1:0]),
        .i_b   (r_dut_in[I_W-1:OPW]),
        .o_abs (w_exact)
    );

    assign w_busy   = (r_state == S_DRIVE) || (r_state == S_WAIT)
                    || (r_state == S_SAMPLE);
    assign w_accept = bus.start && !w_busy;
    assign w_abort  = bus.abort && w_busy;
    assign w_last   = (r_vec == LAST);
    assign w_err    = (bus.dut_out >= w_exact) ? (bus.dut_out - w_exact)
                                               : (w_exact - bus.dut_out);
    assign w_viol   = int'(w_err) > ET;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Next state: start only when idle, abort only while sweeping.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) w_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                w_nxt = bus.abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.abort)             w_nxt = S_IDLE;
                else if (r_set == STW'(1)) w_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (bus.abort)   w_nxt = S_IDLE;
                else if (w_last) w_nxt = S_DONE;
                else             w_nxt = S_DRIVE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Vector counter, settle timer and error accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_set    <= '0;
            r_dut_in <= '0;
            r_max    <= '0;
            r_sum    <= '0;
            r_viol   <= '0;
            r_ffv    <= '0;
            r_done   <= 1'b0;
        end else if (w_accept) begin
            r_vec  <= '0;
            r_max  <= '0;
            r_sum  <= '0;
            r_viol <= '0;
            r_ffv  <= '0;
            r_done <= 1'b0;
        end else if (w_abort) begin
            r_done <= 1'b0;
        end else begin
            case (r_state)
                S_DRIVE: begin
                    r_dut_in <= r_vec[I_W-1:0];
                    r_set    <= STW'(SETTLE);
                end
                S_WAIT: begin
                    r_set <= r_set - STW'(1);
                end
                S_SAMPLE: begin
                    if (w_err > r_max) r_max <= w_err;
                    r_sum <= r_sum + SW'(w_err);
                    if (w_viol) begin
                        r_viol <= r_viol + CW'(1);
                        if (r_viol == '0) r_ffv <= r_dut_in;
                    end
                    if (w_last) r_done <= 1'b1;
                    else        r_vec  <= r_vec + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = w_busy;
    assign bus.done           = r_done;
    assign bus.dut_in         = r_dut_in;
    assign bus.max_err        = r_max;
    assign bus.err_sum        = r_sum;
    assign bus.viol_cnt       = r_viol;
    assign bus.first_fail_vec = r_ffv;
    assign bus.pass           = r_done && (r_viol == '0);
endmodule
